// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with a registered read port,
// occupancy counter, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow error flags. Storage is never cleared; only the
// control state (pointers, count, read register, error flags) is reset.
module fifo_param #(
    parameter int BITNUMBER = 6,
    parameter int LENGTH    = 16,
    parameter int ADDR      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITNUMBER-1:0] data_in,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ADDR:0]        th_full,
    input  logic [ADDR:0]        th_empty,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    output logic [ADDR:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR:0]   FULL_COUNT = (ADDR+1)'(LENGTH);
    localparam logic [ADDR:0]   COUNT_ONE  = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] PTR_ONE    = ADDR'(1);

    logic [BITNUMBER-1:0] mem [LENGTH];
    logic [ADDR-1:0]      wr_ptr;
    logic [ADDR-1:0]      rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    // Accept decisions: a push into a full FIFO is allowed only when a pop
    // frees a slot on the same edge; there is no empty-FIFO bypass.
    always_comb begin
        push_ok = push && (!full || pop);
        pop_ok  = pop && !empty;
    end

    // Status flags decoded from the registered count and live thresholds.
    always_comb begin
        full         = (count == FULL_COUNT);
        empty        = (count == '0);
        almost_full  = (count >= th_full);
        almost_empty = (count <= th_empty);
    end

    // Storage write; deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Control state: pointers, occupancy, read register and sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                data_out  <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_ONE;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
            if (push_ok && !pop_ok) begin
                count <= count + COUNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count <= count - COUNT_ONE;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed and randomized checks of fifo_param against a
// queue-based reference model of the FIFO's visible behaviour.
module tb_fifo_param;

    localparam int BITNUMBER = 6;
    localparam int LENGTH    = 16;
    localparam int ADDR      = 4;

    logic                 clk;
    logic                 reset;
    logic [BITNUMBER-1:0] data_in;
    logic                 push;
    logic                 pop;
    logic [ADDR:0]        th_full;
    logic [ADDR:0]        th_empty;
    logic [BITNUMBER-1:0] data_out;
    logic                 valid_out;
    logic [ADDR:0]        count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 overflow;
    logic                 underflow;

    // Reference model state.
    logic [BITNUMBER-1:0] q [$];
    logic [BITNUMBER-1:0] exp_data;
    logic                 exp_valid;
    logic                 exp_ovf;
    logic                 exp_unf;

    int n_checks;
    int n_fail;

    fifo_param #(
        .BITNUMBER(BITNUMBER),
        .LENGTH   (LENGTH),
        .ADDR     (ADDR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .push        (push),
        .pop         (pop),
        .th_full     (th_full),
        .th_empty    (th_empty),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        int n;
        n = q.size();
        check_output({where, ":count"},        32'(count),        32'(n));
        check_output({where, ":full"},         32'(full),         32'(n == LENGTH));
        check_output({where, ":empty"},        32'(empty),        32'(n == 0));
        check_output({where, ":almost_full"},  32'(almost_full),  32'(n >= int'(th_full)));
        check_output({where, ":almost_empty"}, 32'(almost_empty), 32'(n <= int'(th_empty)));
        check_output({where, ":valid_out"},    32'(valid_out),    32'(exp_valid));
        check_output({where, ":data_out"},     32'(data_out),     32'(exp_data));
        check_output({where, ":overflow"},     32'(overflow),     32'(exp_ovf));
        check_output({where, ":underflow"},    32'(underflow),    32'(exp_unf));
    endtask

    // Drive one cycle of requests from the falling edge, update the model,
    // clock it and compare just after the rising edge.
    task automatic apply_stimulus(input logic p, input logic r, input logic [BITNUMBER-1:0] d, input string where);
        bit pop_acc;
        bit push_acc;
        push    = p;
        pop     = r;
        data_in = d;
        pop_acc  = r && (q.size() > 0);
        push_acc = p && ((q.size() < LENGTH) || r);
        if (pop_acc) begin
            exp_data  = q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (push_acc) q.push_back(d);
        if (p && !push_acc) exp_ovf = 1'b1;
        if (r && !pop_acc) exp_unf = 1'b1;
        @(posedge clk);
        #1;
        check_all(where);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    initial begin
        logic [BITNUMBER-1:0] d;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = '0;
        th_full  = 5'd12;
        th_empty = 5'd3;
        model_reset();

        // Reset state.
        @(negedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Fill 0x01..0x10, then drain in order.
        for (int i = 1; i <= LENGTH; i++) apply_stimulus(1'b1, 1'b0, 6'(i), "fill");
        for (int i = 0; i < LENGTH; i++) apply_stimulus(1'b0, 1'b1, 6'h00, "drain");

        // Overflow: push 0x3F while full, then drain without seeing it.
        for (int i = 1; i <= LENGTH; i++) apply_stimulus(1'b1, 1'b0, 6'(i), "fill2");
        apply_stimulus(1'b1, 1'b0, 6'h3F, "overflow");
        apply_stimulus(1'b0, 1'b0, 6'h00, "ovf_sticky");
        for (int i = 0; i < LENGTH; i++) apply_stimulus(1'b0, 1'b1, 6'h00, "drain2");

        // Underflow with simultaneous push on empty, then read the word back.
        apply_stimulus(1'b1, 1'b1, 6'h2A, "empty_both");
        apply_stimulus(1'b0, 1'b1, 6'h00, "read_2a");
        apply_stimulus(1'b0, 1'b1, 6'h00, "pop_empty");

        // Push+pop at full for 40 cycles across pointer wrap.
        for (int i = 0; i < LENGTH; i++) apply_stimulus(1'b1, 1'b0, 6'(i + 8'h20), "fill3");
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 1'b1, 6'(i), "wrap_full");
        // Same at half occupancy.
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 6'h00, "to_half");
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 1'b1, 6'(i + 7), "wrap_half");

        // Threshold changes take effect combinationally at count 8.
        th_full = 5'd5;
        #1;
        check_all("th_full_5");
        th_full = 5'd0;
        th_empty = 5'd16;
        #1;
        check_all("th_extremes");
        th_full = 5'd16;
        th_empty = 5'd0;
        #1;
        check_all("th_tight");
        @(negedge clk);
        th_full  = 5'd12;
        th_empty = 5'd3;
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 6'h00, "drain3");

        // Randomized traffic with occasional threshold changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                th_full  = 5'($urandom_range(0, LENGTH));
                th_empty = 5'($urandom_range(0, LENGTH));
            end
            d = 6'($urandom);
            apply_stimulus(1'($urandom), 1'($urandom), d, "random");
        end

        // Reset asserted mid-traffic discards everything.
        th_full  = 5'd12;
        th_empty = 5'd3;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 6'(i + 1), "pre_reset");
        push  = 1'b1;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        push  = 1'b0;
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b0, 6'h15, "post_reset_push");
        apply_stimulus(1'b0, 1'b1, 6'h00, "post_reset_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
